// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_pkg                                                     |
// | Description : Shared state encoding and sizing helper for the 1-D          |
// |               convolution sequencer.                                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package conv_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } seq_state_t;

    // Number of valid (no-padding) output samples for one data set
    function automatic int y_cnt(input int x_len, input int f_len);
        return x_len - f_len + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_addr_gen                                                |
// | Description : Tap counter, X/F read address generation and the one-cycle  |
// |               delayed MAC operand strobe for the RUN phase.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module conv_addr_gen #(
    parameter int F_LEN = 49,
    parameter int XA    = 7,
    parameter int FA    = 6,
    parameter int YA    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          run,
    input  logic [YA-1:0] base,
    output logic [XA-1:0] addr_x,
    output logic [FA-1:0] addr_f,
    output logic          mac_valid_in,
    output logic          last
);

    logic [FA-1:0] r_j;
    logic          r_mac_valid_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_j            <= '0;
            r_mac_valid_in <= 1'b0;
        end else begin
            // Read data arrives one cycle after the address, so the strobe lags issue
            r_mac_valid_in <= run;
            if (clear || last)
                r_j <= '0;
            else if (run)
                r_j <= r_j + 1'b1;
        end
    end

    assign last         = run && (r_j == FA'(F_LEN - 1));
    assign addr_x       = run ? (XA'(base) + XA'(r_j)) : '0;
    assign addr_f       = run ? r_j : '0;
    assign mac_valid_in = r_mac_valid_in;

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_sequencer                                               |
// | Description : Loads X/F memories, sequences dot products through the MAC  |
// |               and hands each Y sample downstream with valid/ready.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int X_LEN = 112,
    parameter int F_LEN = 49,
    localparam int XA    = $clog2(X_LEN),
    localparam int FA    = $clog2(F_LEN),
    localparam int Y_CNT = y_cnt(X_LEN, F_LEN),
    localparam int YA    = $clog2(Y_CNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic          f_valid,
    output logic          f_ready,
    output logic [XA-1:0] addr_x,
    output logic          wr_en_x,
    output logic [FA-1:0] addr_f,
    output logic          wr_en_f,
    output logic          mac_valid_in,
    output logic          mac_clear,
    input  logic          mac_valid_out,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [YA-1:0] y_index
);

    localparam int XC = $clog2(X_LEN + 1);
    localparam int FC = $clog2(F_LEN + 1);

    seq_state_t    r_state;
    logic [XC-1:0] r_x_cnt;
    logic [FC-1:0] r_f_cnt;
    logic [FC-1:0] r_done_cnt;
    logic [YA-1:0] r_y_index;

    logic          w_load;
    logic          w_run;
    logic          w_x_acc;
    logic          w_f_acc;
    logic          w_last;
    logic [FC-1:0] w_done_next;
    logic [XA-1:0] w_gen_addr_x;
    logic [FA-1:0] w_gen_addr_f;
    logic          w_gen_mvi;

    conv_addr_gen #(
        .F_LEN (F_LEN),
        .XA    (XA),
        .FA    (FA),
        .YA    (YA)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .clear        (r_state == CLEAR),
        .run          (w_run),
        .base         (r_y_index),
        .addr_x       (w_gen_addr_x),
        .addr_f       (w_gen_addr_f),
        .mac_valid_in (w_gen_mvi),
        .last         (w_last)
    );

    // Everything except mac_clear is forced low while reset is held
    assign w_load       = !reset && (r_state == LOAD);
    assign w_run        = !reset && (r_state == RUN);
    assign x_ready      = w_load && (r_x_cnt < XC'(X_LEN));
    assign f_ready      = w_load && (r_f_cnt < FC'(F_LEN));
    assign w_x_acc      = x_valid && x_ready;
    assign w_f_acc      = f_valid && f_ready;
    assign wr_en_x      = w_x_acc;
    assign wr_en_f      = w_f_acc;
    assign addr_x       = w_load ? r_x_cnt[XA-1:0] : w_gen_addr_x;
    assign addr_f       = w_load ? r_f_cnt[FA-1:0] : w_gen_addr_f;
    assign mac_valid_in = !reset && w_gen_mvi;
    assign mac_clear    = reset || (r_state == CLEAR);
    assign y_valid      = !reset && (r_state == OUT);
    assign y_index      = reset ? '0 : r_y_index;
    assign w_done_next  = r_done_cnt + FC'(mac_valid_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LOAD;
            r_x_cnt    <= '0;
            r_f_cnt    <= '0;
            r_done_cnt <= '0;
            r_y_index  <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_x_acc) r_x_cnt <= r_x_cnt + 1'b1;
                    if (w_f_acc) r_f_cnt <= r_f_cnt + 1'b1;
                    if (r_x_cnt == XC'(X_LEN) && r_f_cnt == FC'(F_LEN))
                        r_state <= CLEAR;
                end
                CLEAR: begin
                    r_done_cnt <= '0;
                    r_state    <= RUN;
                end
                RUN: begin
                    // Early products may already retire before the last address issues
                    r_done_cnt <= w_done_next;
                    if (w_last) r_state <= DRAIN;
                end
                DRAIN: begin
                    r_done_cnt <= w_done_next;
                    if (w_done_next == FC'(F_LEN)) r_state <= OUT;
                end
                OUT: begin
                    if (y_ready) begin
                        if (r_y_index == YA'(Y_CNT - 1)) begin
                            r_y_index <= '0;
                            r_x_cnt   <= '0;
                            r_f_cnt   <= '0;
                            r_state   <= LOAD;
                        end else begin
                            r_y_index <= r_y_index + 1'b1;
                            r_state   <= CLEAR;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv_sequencer                                            |
// | Description : Directed bench: sequencer with behavioural X/F memories and  |
// |               a 3-stage saturating MAC (X_LEN=8, F_LEN=3, WIDTH=10).       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_conv_sequencer;

    localparam int X_LEN   = 8;
    localparam int F_LEN   = 3;
    localparam int SAT_MAX = 524287;

    logic                clk = 1'b0;
    logic                reset;
    logic                x_valid, x_ready, f_valid, f_ready;
    logic [2:0]          addr_x;
    logic [1:0]          addr_f;
    logic                wr_en_x, wr_en_f;
    logic                mac_valid_in, mac_clear, mac_valid_out;
    logic                y_valid, y_ready;
    logic [2:0]          y_index;

    logic signed [9:0]   x_data, f_data;
    logic signed [9:0]   x_mem [0:7];
    logic signed [9:0]   f_mem [0:3];
    logic signed [9:0]   x_rd, f_rd;
    logic signed [19:0]  p1, p2, acc;
    logic                p1_v, p2_v;
    logic                y_prev;
    int                  y_pulses = 0;
    int                  checks = 0;
    int                  errors = 0;
    int                  base;

    always #5 clk = ~clk;

    conv_sequencer #(.X_LEN(X_LEN), .F_LEN(F_LEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .x_valid       (x_valid),
        .x_ready       (x_ready),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .addr_x        (addr_x),
        .wr_en_x       (wr_en_x),
        .addr_f        (addr_f),
        .wr_en_f       (wr_en_f),
        .mac_valid_in  (mac_valid_in),
        .mac_clear     (mac_clear),
        .mac_valid_out (mac_valid_out),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .y_index       (y_index)
    );

    function automatic logic signed [19:0] sat(input logic signed [20:0] s);
        if (s > 21'sd524287)  return 20'sd524287;
        if (s < -21'sd524288) return -20'sd524288;
        return s[19:0];
    endfunction

    // Memories with one-cycle read latency and a MAC retiring 3 cycles after its strobe
    always @(posedge clk) begin
        x_rd <= x_mem[addr_x];
        f_rd <= f_mem[addr_f];
        if (wr_en_x) x_mem[addr_x] <= x_data;
        if (wr_en_f) f_mem[addr_f] <= f_data;
        if (mac_clear) begin
            p1_v <= 1'b0; p2_v <= 1'b0; mac_valid_out <= 1'b0; acc <= '0;
        end else begin
            p1_v <= mac_valid_in;
            p1   <= x_rd * f_rd;
            p2_v <= p1_v;
            p2   <= p1;
            mac_valid_out <= p2_v;
            if (p2_v) acc <= sat(21'(acc) + 21'(p2));
        end
    end

    always @(posedge clk) begin
        y_prev <= y_valid;
        if (y_valid && !y_prev) y_pulses <= y_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_set(input bit saturate);
        int xi = 0;
        int fi = 0;
        int n  = 0;
        bit xv, fv;
        while ((xi < X_LEN || fi < F_LEN) && n < 200) begin
            xv = 1'($urandom_range(0, 1));
            fv = 1'($urandom_range(0, 1));
            x_valid = xv;
            f_valid = fv;
            x_data  = saturate ? 10'sd511 : 10'(xi + 1);
            f_data  = saturate ? 10'sd511 : 10'sd1;
            #1;
            chk("x_ready_ld", x_ready, xi < X_LEN);
            chk("f_ready_ld", f_ready, fi < F_LEN);
            chk("wr_en_x_ld", wr_en_x, xv && xi < X_LEN);
            chk("wr_en_f_ld", wr_en_f, fv && fi < F_LEN);
            if (xv && xi < X_LEN) chk("addr_x_ld", addr_x, xi);
            if (fv && fi < F_LEN) chk("addr_f_ld", addr_f, fi);
            @(posedge clk); #2;
            if (xv && xi < X_LEN) xi++;
            if (fv && fi < F_LEN) fi++;
            n++;
        end
        chk("load_done", n < 200, 1);
        x_valid = 1'b1;
        f_valid = 1'b1;
        #1;
        chk("x_ready_full", x_ready, 0);
        chk("f_ready_full", f_ready, 0);
        chk("wr_en_x_full", wr_en_x, 0);
        chk("wr_en_f_full", wr_en_f, 0);
        @(posedge clk); #2;
        x_valid = 1'b0;
        f_valid = 1'b0;
    endtask

    task automatic run_y(input int idx, input logic [31:0] exp, input int exp_gap, input bit stall);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!y_valid && n < 100);
        chk("y_seen", y_valid, 1);
        if (exp_gap > 0) chk("y_gap", n, exp_gap);
        chk("y_index", y_index, idx);
        chk("y_value", acc, exp);
        if (stall) begin
            y_ready = 1'b0;
            repeat (5) begin
                @(posedge clk); #2;
                chk("stall_valid", y_valid, 1);
                chk("stall_index", y_index, idx);
                chk("stall_value", acc, exp);
            end
            y_ready = 1'b1;
            @(posedge clk); #2;
            chk("stall_drop", y_valid, 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        f_valid = 1'b0;
        y_ready = 1'b1;
        x_data  = '0;
        f_data  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_f_ready", f_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_wr_en_x", wr_en_x, 0);
        chk("rst_mvi", mac_valid_in, 0);
        chk("rst_y_index", y_index, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_x_ready", x_ready, 1);
        chk("post_rst_f_ready", f_ready, 1);
        chk("post_rst_clear", mac_clear, 0);

        // Pass 1: x=1..8, f=1,1,1 with a 5-cycle stall on Y#2
        base = y_pulses;
        load_set(1'b0);
        run_y(0, 6, 0, 1'b0);
        for (int i = 1; i < 6; i++)
            run_y(i, 6 + 3 * i, (i == 3) ? 8 : 9, i == 2);
        @(posedge clk); #2;
        chk("ret_y_valid", y_valid, 0);
        chk("ret_x_ready", x_ready, 1);
        chk("pulses_p1", y_pulses - base, 6);

        // Pass 2: reset in the middle of Y#3's RUN phase
        load_set(1'b0);
        run_y(0, 6, 0, 1'b0);
        run_y(1, 9, 9, 1'b0);
        run_y(2, 12, 9, 1'b0);
        @(posedge clk); #2;
        chk("clr_mac_clear", mac_clear, 1);
        @(posedge clk); #2;
        chk("run0_addr_x", addr_x, 3);
        chk("run0_addr_f", addr_f, 0);
        chk("run0_mvi", mac_valid_in, 0);
        chk("run0_clear", mac_clear, 0);
        @(posedge clk); #2;
        chk("run1_addr_x", addr_x, 4);
        chk("run1_addr_f", addr_f, 1);
        chk("run1_mvi", mac_valid_in, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_clear", mac_clear, 1);
        chk("mid_rst_mvi", mac_valid_in, 0);
        chk("mid_rst_y_valid", y_valid, 0);
        @(posedge clk); #2;
        chk("mid_rst2_clear", mac_clear, 1);
        chk("mid_rst2_y_valid", y_valid, 0);
        chk("mid_rst2_x_ready", x_ready, 0);
        reset = 1'b0;
        #1;
        chk("mid_post_x_ready", x_ready, 1);
        chk("mid_post_f_ready", f_ready, 1);
        chk("mid_post_clear", mac_clear, 0);

        // Pass 3: fresh load after reset reproduces the same results
        base = y_pulses;
        load_set(1'b0);
        run_y(0, 6, 0, 1'b0);
        for (int i = 1; i < 6; i++)
            run_y(i, 6 + 3 * i, 9, 1'b0);
        @(posedge clk); #2;
        chk("ret3_x_ready", x_ready, 1);
        chk("pulses_p3", y_pulses - base, 6);

        // Pass 4: full-scale operands saturate the accumulator
        base = y_pulses;
        load_set(1'b1);
        run_y(0, SAT_MAX, 0, 1'b0);
        for (int i = 1; i < 6; i++)
            run_y(i, SAT_MAX, 9, 1'b0);
        @(posedge clk); #2;
        chk("ret4_y_valid", y_valid, 0);
        chk("pulses_sat", y_pulses - base, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
